// File: rtl/accuracy_level_controller_pkg.sv
// rtl/accuracy_level_controller_pkg.sv - shared constants, FSM encoding and level-update rule
package accuracy_level_controller_pkg;

  localparam int ACCURACY_WIDTH = 8;
  localparam int DATA_WIDTH     = 32;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ACCUMULATE = 2'd1,
    ST_EVALUATE   = 2'd2
  } alc_state_e;

  // Too much error -> step towards exact; comfortably low error -> step towards approximate.
  function automatic logic [ACCURACY_WIDTH-1:0] next_level(
    input logic [DATA_WIDTH-1:0]     sum,
    input logic [DATA_WIDTH-1:0]     threshold,
    input logic [ACCURACY_WIDTH-1:0] level,
    input logic [ACCURACY_WIDTH-1:0] max_level
  );
    if ((sum > threshold) && (level != '0))
      return level - ACCURACY_WIDTH'(1);
    else if ((sum <= (threshold >> 1)) && (level < max_level))
      return level + ACCURACY_WIDTH'(1);
    else
      return level;
  endfunction

endpackage

// File: rtl/accuracy_level_controller_if.sv
// rtl/accuracy_level_controller_if.sv - sample/result bundle between an ALU monitor and the controller
import accuracy_level_controller_pkg::*;

interface accuracy_level_controller_if;
  logic                      enable;
  logic                      sample_valid;
  logic [DATA_WIDTH-1:0]     approximate_result;
  logic [DATA_WIDTH-1:0]     exact_result;
  logic [ACCURACY_WIDTH-1:0] accuracy_level;
  logic [DATA_WIDTH-1:0]     window_error;
  logic                      window_done;
  logic                      saturated;

  modport master (
    output enable, sample_valid, approximate_result, exact_result,
    input  accuracy_level, window_error, window_done, saturated
  );

  modport slave (
    input  enable, sample_valid, approximate_result, exact_result,
    output accuracy_level, window_error, window_done, saturated
  );
endinterface

// File: rtl/accuracy_level_controller_absolute_error_unit.sv
// rtl/accuracy_level_controller_absolute_error_unit.sv - unsigned |a - b| magnitude
import accuracy_level_controller_pkg::*;

module absolute_error_unit (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] err_o
);

  // Subtract the smaller from the larger so the result never wraps.
  assign err_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);

endmodule

// File: rtl/accuracy_level_controller.sv
// rtl/accuracy_level_controller.sv - windowed error monitor that adapts the ALU accuracy level
import accuracy_level_controller_pkg::*;

module accuracy_level_controller #(
  parameter int                      WINDOW          = 16,
  parameter logic [DATA_WIDTH-1:0]   ERROR_THRESHOLD = 32'd64,
  parameter logic [ACCURACY_WIDTH-1:0] MAX_LEVEL     = 8'd3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      sample_valid,
  input  logic [DATA_WIDTH-1:0]     approximate_result,
  input  logic [DATA_WIDTH-1:0]     exact_result,
  output logic [ACCURACY_WIDTH-1:0] accuracy_level,
  output logic [DATA_WIDTH-1:0]     window_error,
  output logic                      window_done,
  output logic                      saturated
);

  localparam int CNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;

  alc_state_e                state_q;
  logic [CNT_W-1:0]          count_q;
  logic [DATA_WIDTH-1:0]     acc_q;
  logic                      sat_q;
  logic [ACCURACY_WIDTH-1:0] level_q;
  logic [DATA_WIDTH-1:0]     window_error_q;
  logic                      window_done_q;
  logic                      saturated_q;

  logic [DATA_WIDTH-1:0]     abs_err;
  logic [DATA_WIDTH:0]       acc_sum;
  logic [DATA_WIDTH-1:0]     acc_d;
  logic                      sat_d;
  logic [ACCURACY_WIDTH-1:0] level_d;
  logic                      last_sample;

  absolute_error_unit u_abs (
    .a_i   (approximate_result),
    .b_i   (exact_result),
    .err_o (abs_err)
  );

  // Saturating accumulate and the level the current window would produce.
  always_comb begin
    acc_sum     = {1'b0, acc_q} + {1'b0, abs_err};
    acc_d       = acc_sum[DATA_WIDTH] ? '1 : acc_sum[DATA_WIDTH-1:0];
    sat_d       = sat_q | acc_sum[DATA_WIDTH];
    level_d     = next_level(acc_q, ERROR_THRESHOLD, level_q, MAX_LEVEL);
    last_sample = (count_q == CNT_W'(WINDOW - 1));
  end

  // Window FSM with registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      count_q        <= '0;
      acc_q          <= '0;
      sat_q          <= 1'b0;
      level_q        <= '0;
      window_error_q <= '0;
      window_done_q  <= 1'b0;
      saturated_q    <= 1'b0;
    end else begin
      window_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q <= ST_ACCUMULATE;
            count_q <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
          end
        end
        ST_ACCUMULATE: begin
          if (!enable) begin
            // Partial window is dropped; published results stay as they were.
            state_q <= ST_IDLE;
            count_q <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
          end else if (sample_valid) begin
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            count_q <= count_q + CNT_W'(1);
            if (last_sample) state_q <= ST_EVALUATE;
          end
        end
        ST_EVALUATE: begin
          window_error_q <= acc_q;
          saturated_q    <= sat_q;
          window_done_q  <= 1'b1;
          level_q        <= level_d;
          count_q        <= '0;
          acc_q          <= '0;
          sat_q          <= 1'b0;
          state_q        <= enable ? ST_ACCUMULATE : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign accuracy_level = level_q;
  assign window_error   = window_error_q;
  assign window_done    = window_done_q;
  assign saturated      = saturated_q;

endmodule

// File: tb/tb_accuracy_level_controller.sv
// tb/tb_accuracy_level_controller.sv - directed self-checking bench for accuracy_level_controller
import accuracy_level_controller_pkg::*;

module tb_accuracy_level_controller;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  accuracy_level_controller_if bus ();

  accuracy_level_controller #(
    .WINDOW          (4),
    .ERROR_THRESHOLD (32'd64),
    .MAX_LEVEL       (8'd3)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (bus.enable),
    .sample_valid       (bus.sample_valid),
    .approximate_result (bus.approximate_result),
    .exact_result       (bus.exact_result),
    .accuracy_level     (bus.accuracy_level),
    .window_error       (bus.window_error),
    .window_done        (bus.window_done),
    .saturated          (bus.saturated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed one full window (already in ACCUMULATE) and check the evaluation that follows.
  task automatic run_window(input string tag, input logic [31:0] a, input logic [31:0] e,
                            input logic [31:0] exp_err, input logic exp_sat,
                            input logic [7:0] exp_lvl);
    bus.sample_valid       = 1'b1;
    bus.approximate_result = a;
    bus.exact_result       = e;
    for (int i = 0; i < 4; i++) begin
      tick();
      check({tag, "_nodone"}, 32'(bus.window_done), 32'd0);
    end
    bus.sample_valid = 1'b0;
    check({tag, "_eval_state"}, 32'(dut.state_q), 32'(ST_EVALUATE));
    tick();
    check({tag, "_done"}, 32'(bus.window_done), 32'd1);
    check({tag, "_err"}, bus.window_error, exp_err);
    check({tag, "_sat"}, 32'(bus.saturated), 32'(exp_sat));
    check({tag, "_lvl"}, 32'(bus.accuracy_level), 32'(exp_lvl));
    tick();
    check({tag, "_pulse_end"}, 32'(bus.window_done), 32'd0);
  endtask

  initial begin
    n_checks               = 0;
    n_errors               = 0;
    reset                  = 1'b1;
    bus.enable             = 1'b0;
    bus.sample_valid       = 1'b0;
    bus.approximate_result = '0;
    bus.exact_result       = '0;

    tick();
    tick();
    check("rst_lvl", 32'(bus.accuracy_level), 32'd0);
    check("rst_err", bus.window_error, 32'd0);
    check("rst_done", 32'(bus.window_done), 32'd0);
    check("rst_sat", 32'(bus.saturated), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

    reset      = 1'b0;
    bus.enable = 1'b1;
    tick();
    check("start_state", 32'(dut.state_q), 32'(ST_ACCUMULATE));

    run_window("inc",      32'd9,          32'd5 + 32'd4, 32'd0,          1'b0, 8'd1);
    run_window("dec",      32'd25,         32'd5,         32'd80,         1'b0, 8'd0);
    run_window("hold",     32'd5,          32'd15,        32'd40,         1'b0, 8'd0);
    run_window("thr_eq",   32'd4,          32'd20,        32'd64,         1'b0, 8'd0);
    run_window("half_eq",  32'd13,         32'd5,         32'd32,         1'b0, 8'd1);
    run_window("satur",    32'hFFFF_FFFF,  32'd0,         32'hFFFF_FFFF,  1'b1, 8'd0);
    run_window("post_sat", 32'd9,          32'd9,         32'd0,          1'b0, 8'd1);

    // Abort after two samples, then restart with samples presented while idle.
    bus.sample_valid       = 1'b1;
    bus.approximate_result = 32'd25;
    bus.exact_result       = 32'd5;
    tick();
    tick();
    check("abort_pre_done", 32'(bus.window_done), 32'd0);
    bus.enable = 1'b0;
    tick();
    check("abort_done", 32'(bus.window_done), 32'd0);
    check("abort_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("abort_lvl", 32'(bus.accuracy_level), 32'd1);
    tick();
    check("idle_done", 32'(bus.window_done), 32'd0);
    check("idle_lvl", 32'(bus.accuracy_level), 32'd1);
    bus.enable = 1'b1;
    tick();
    check("restart_state", 32'(dut.state_q), 32'(ST_ACCUMULATE));
    run_window("restart", 32'd9, 32'd9, 32'd0, 1'b0, 8'd2);
    run_window("to_max",  32'd9, 32'd9, 32'd0, 1'b0, 8'd3);
    run_window("at_max",  32'd9, 32'd9, 32'd0, 1'b0, 8'd3);

    // Reset in the middle of a window.
    bus.sample_valid       = 1'b1;
    bus.approximate_result = 32'd100;
    bus.exact_result       = 32'd0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_done", 32'(bus.window_done), 32'd0);
    check("mid_rst_lvl", 32'(bus.accuracy_level), 32'd0);
    check("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    reset            = 1'b0;
    bus.sample_valid = 1'b0;
    tick();
    check("post_rst_done", 32'(bus.window_done), 32'd0);
    run_window("after_rst", 32'd9, 32'd9, 32'd0, 1'b0, 8'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/accuracy_level_controller.md
ACCURACY_LEVEL_CONTROLLER -- requirements
Module: accuracy_level_controller

Interface
REQ-001 SHALL have parameter WINDOW, default 16, samples per evaluation window (power of two, 2..256).
REQ-002 SHALL have parameter ERROR_THRESHOLD, default 32'd64, window error above which accuracy is raised.
REQ-003 SHALL have parameter MAX_LEVEL, default 8'd3, highest permitted accuracy_level (0 = exact ALU, higher = more approximate).
REQ-004 SHALL use a single clock and a synchronous, active-high reset, with ports exactly as follows.
REQ-005 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port: enable  input  1  run adaptive control; low = hold the current level.
REQ-008 SHALL have port: sample_valid  input  1  approximate_result/exact_result valid this cycle.
REQ-009 SHALL have port: approximate_result  input  32  output of the approximate ALU.
REQ-010 SHALL have port: exact_result  input  32  exact reference result for the same operation.
REQ-011 SHALL have port: accuracy_level  output  8  level driven to the approximate ALU's accuracy_level input.
REQ-012 SHALL have port: window_error  output  32  saturated error sum of the last completed window.
REQ-013 SHALL have port: window_done  output  1  one-cycle pulse when a window is evaluated.
REQ-014 SHALL have port: saturated  output  1  last completed window's error sum saturated.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUMULATE and EVALUATE.
REQ-016 SHALL go from IDLE to ACCUMULATE on an edge with enable=1, with sample count and accumulator cleared.
REQ-017 SHALL, in ACCUMULATE on each edge with sample_valid=1, add |approximate_result - exact_result| (unsigned operands, 32-bit magnitude) to a 32-bit accumulator and increment the sample count.
REQ-018 SHALL clamp the accumulator at 32'hFFFF_FFFF on overflow and set an internal saturation flag.
REQ-019 SHALL enter EVALUATE on the edge that accepts the WINDOW-th sample.
REQ-020 SHALL, on the edge leaving EVALUATE, update window_error and saturated from the window, assert window_done for exactly one cycle, and apply rule REQ-021.
REQ-021 SHALL set the new level as follows: sum > ERROR_THRESHOLD and level > 0 gives level-1; sum <= ERROR_THRESHOLD/2 and level < MAX_LEVEL gives level+1; otherwise the level holds.
REQ-022 SHALL leave EVALUATE after exactly one cycle, to ACCUMULATE (count and accumulator cleared) if enable=1, else to IDLE.
REQ-023 SHALL ignore sample_valid while in EVALUATE or IDLE.
REQ-024 SHALL, when enable=0 in ACCUMULATE, go to IDLE, discard the partial window without a window_done pulse, and leave the level, window_error and saturated unchanged.
REQ-025 SHALL change accuracy_level only on a window_done edge or on reset.

Reset
REQ-026 SHALL, on reset=1 at a rising edge, force state IDLE, accuracy_level=0, window_error=0, window_done=0, saturated=0, and clear the count and accumulator.
REQ-027 SHALL have reset take priority over every event, including a reset in the middle of a window or during EVALUATE, with no window_done pulse.

Structure
REQ-028 SHALL take the FSM state encodings and ACCURACY_WIDTH=8 from the shared core constants package.
REQ-029 SHALL compute the magnitude in one combinational sub-module, absolute_error_unit (two 32-bit inputs, 32-bit output).

Verification (WINDOW=4, ERROR_THRESHOLD=64, MAX_LEVEL=3)
REQ-030 SHALL check reset: assert reset 2 cycles -> all outputs 0 and state IDLE.
REQ-031 SHALL check level increase: level 0, enable=1, 4 samples of approx=9, exact=9 -> window_done pulse 1 cycle, window_error=0, accuracy_level=1.
REQ-032 SHALL check level decrease: from level 1, 4 samples of approx=25, exact=5 (sum 80) -> accuracy_level=0, window_error=80.
REQ-033 SHALL check the hold band: 4 samples of approx=5, exact=15 (sum 40, reversed sign) -> level unchanged, window_error=40.
REQ-034 SHALL check saturation: 4 samples of approx=32'hFFFFFFFF, exact=0 -> window_error=32'hFFFFFFFF, saturated=1, level decremented (floored at 0).
REQ-035 SHALL check abort and restart: drop enable after 2 samples -> no window_done, level held; re-enable plus 4 samples -> first window_done only after those 4; reset asserted mid-window likewise gives no pulse.
